// File: rtl/clk_div_pkg.sv
// Shared types and sizing helpers for the clk_div_seq control slice.
package clk_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR_HOLD,
    SETTLE,
    RUN,
    DRAIN
  } clk_div_seq_state_t;

  localparam int unsigned DIV_MAX = 8;

  function automatic int unsigned cnt_w(input int unsigned clr_cyc,
                                        input int unsigned settle_cyc,
                                        input int unsigned div);
    int unsigned m;
    m = clr_cyc;
    if (settle_cyc > m) m = settle_cyc;
    if (div > m) m = div;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/clk_div_seq_if.sv
// Control/status bundle between local control logic (master) and clk_div_seq (slave).
interface clk_div_seq_if;
  logic en_i;
  logic restart_i;
  logic ce_o;
  logic clr_o;
  logic running_o;
  logic busy_o;
  logic phase_o;

  modport master (
    output en_i, restart_i,
    input  ce_o, clr_o, running_o, busy_o, phase_o
  );

  modport slave (
    input  en_i, restart_i,
    output ce_o, clr_o, running_o, busy_o, phase_o
  );
endinterface

// File: rtl/clk_div_phase.sv
// Divided-edge strobe generator: one phase_o pulse every DIV RUN cycles.
module clk_div_phase
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_nxt,
  output logic phase_o
);

  localparam int unsigned PW = $clog2(DIV_MAX);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  // Holds the phase of the upcoming cycle so the strobe can be registered;
  // parked at 0 outside RUN so the first RUN cycle strobes.
  logic [PW-1:0] ph_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_cnt  <= '0;
      phase_o <= 1'b0;
    end else if (!run_nxt) begin
      ph_cnt  <= '0;
      phase_o <= 1'b0;
    end else begin
      phase_o <= (ph_cnt == '0);
      ph_cnt  <= (ph_cnt == LAST) ? '0 : ph_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/clk_div_seq.sv
// CE/CLR sequencer for a BUFGCE_DIV divider. Optional strobe: CLK_DIV_SEQ_PHASE_EN.
module clk_div_seq
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV        = 4,
  parameter int unsigned CLR_CYC    = 4,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  clk_div_seq_if.slave  bus
);

  localparam int unsigned CW = cnt_w(CLR_CYC, SETTLE_CYC, DIV);
  localparam logic [CW-1:0] CLR_LD    = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] DRAIN_LD  = CW'(DIV - 1);

  clk_div_seq_state_t state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               rs_flag, rs_flag_nxt;
  logic               ce_nxt, clr_nxt, running_nxt, busy_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      rs_flag       <= 1'b0;
      bus.ce_o      <= 1'b0;
      bus.clr_o     <= 1'b1;
      bus.running_o <= 1'b0;
      bus.busy_o    <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      rs_flag       <= rs_flag_nxt;
      bus.ce_o      <= ce_nxt;
      bus.clr_o     <= clr_nxt;
      bus.running_o <= running_nxt;
      bus.busy_o    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rs_flag_nxt = rs_flag;
    unique case (state)
      IDLE: begin
        if (bus.en_i) begin
          state_nxt = CLR_HOLD;
          cnt_nxt   = CLR_LD;
        end
      end
      CLR_HOLD: begin
        if (!bus.en_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      SETTLE: begin
        if (!bus.en_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RUN: begin
        if (!bus.en_i || bus.restart_i) begin
          state_nxt = DRAIN;
          cnt_nxt   = DRAIN_LD;
          // A restart requested while stopping is just a stop.
          rs_flag_nxt = bus.restart_i & bus.en_i;
        end
      end
      DRAIN: begin
        if (cnt == '0) begin
          rs_flag_nxt = 1'b0;
          if (rs_flag && bus.en_i) begin
            state_nxt = CLR_HOLD;
            cnt_nxt   = CLR_LD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        rs_flag_nxt = 1'b0;
      end
    endcase
  end

  // Outputs decode the next state so they land registered alongside it.
  always_comb begin
    ce_nxt      = 1'b0;
    clr_nxt     = 1'b0;
    running_nxt = 1'b0;
    busy_nxt    = 1'b0;
    unique case (state_nxt)
      IDLE:     clr_nxt = 1'b1;
      CLR_HOLD: begin
        clr_nxt  = 1'b1;
        busy_nxt = 1'b1;
      end
      SETTLE:   busy_nxt = 1'b1;
      RUN: begin
        ce_nxt      = 1'b1;
        running_nxt = 1'b1;
      end
      DRAIN:    busy_nxt = 1'b1;
      default:  clr_nxt = 1'b1;
    endcase
  end

`ifdef CLK_DIV_SEQ_PHASE_EN
  clk_div_phase #(.DIV(DIV)) u_phase (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .run_nxt (state_nxt == RUN),
    .phase_o (bus.phase_o)
  );
`else
  assign bus.phase_o = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_seq.sv
// Scoreboard bench for clk_div_seq: per-cycle expected outputs queued with stimulus.
module tb_clk_div_seq;

`ifdef CLK_DIV_SEQ_PHASE_EN
  localparam int unsigned TB_DIV = 3;
  localparam bit PH_EN = 1'b1;
`else
  localparam int unsigned TB_DIV = 4;
  localparam bit PH_EN = 1'b0;
`endif
  localparam int unsigned TB_CLR = 4;
  localparam int unsigned TB_SET = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  bit   started = 1'b0;

  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];

  clk_div_seq_if bus();

  clk_div_seq #(.DIV(TB_DIV), .CLR_CYC(TB_CLR), .SETTLE_CYC(TB_SET)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if ((bus.ce_o === 1'b1) && (bus.clr_o === 1'b1)) begin
        failures++;
        $display("FAIL ce_clr_overlap t=%0t ce=%b clr=%b required not both 1", $time, bus.ce_o, bus.clr_o);
      end
    end
  end

  // Drive one cycle; st names the state the outputs must show after this edge:
  // I=idle H=clr_hold S=settle R=run D=drain. ridx = RUN cycle index for phase.
  task automatic cyc(input logic en, input logic rs, input logic r, input byte st,
                     input int unsigned ridx);
    logic [4:0] e;
    bus.en_i = en;
    bus.restart_i = rs;
    rst = r;
    if (st == "I")      e = 5'b01000;
    else if (st == "H") e = 5'b01010;
    else if (st == "S") e = 5'b00010;
    else if (st == "D") e = 5'b00010;
    else                e = {4'b1010, PH_EN && ((ridx % TB_DIV) == 0)};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    obs_q.push_back({bus.ce_o, bus.clr_o, bus.running_o, bus.busy_o, bus.phase_o});
  endtask

  task automatic bring_up(input int unsigned nrun);
    for (int unsigned i = 0; i < TB_CLR; i++) cyc(1, 0, 0, "H", 0);
    for (int unsigned i = 0; i < TB_SET; i++) cyc(1, 0, 0, "S", 0);
    for (int unsigned i = 0; i < nrun; i++)   cyc(1, 0, 0, "R", i);
  endtask

  task automatic test_reset();
    logic [4:0] e, o;
    int n = 0;
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, "I", 0);
    started = 1'b1;
    bring_up(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset[%0d] got {ce,clr,run,busy,ph}=%b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_stop();
    logic [4:0] e, o;
    int n = 0;
    cyc(0, 0, 0, "D", 0);
    for (int unsigned i = 1; i < TB_DIV; i++) cyc(logic'(i[0]), 0, 0, "D", 0);
    cyc(1, 0, 0, "I", 0);
    cyc(0, 1, 0, "I", 0);
    cyc(0, 0, 0, "I", 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL stop[%0d] got {ce,clr,run,busy,ph}=%b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_abort();
    logic [4:0] e, o;
    int n = 0;
    cyc(1, 0, 0, "H", 0);
    cyc(1, 1, 0, "H", 0);
    cyc(0, 0, 0, "I", 0);
    cyc(0, 0, 0, "I", 0);
    for (int unsigned i = 0; i < TB_CLR; i++) cyc(1, 0, 0, "H", 0);
    cyc(1, 1, 0, "S", 0);
    cyc(0, 0, 0, "I", 0);
    cyc(0, 0, 0, "I", 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL abort[%0d] got {ce,clr,run,busy,ph}=%b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_restart();
    logic [4:0] e, o;
    int n = 0;
    bring_up(3);
    cyc(1, 1, 0, "D", 0);
    for (int unsigned i = 1; i < TB_DIV; i++) cyc(1, 0, 0, "D", 0);
    bring_up(2);
    cyc(0, 1, 0, "D", 0);
    for (int unsigned i = 1; i < TB_DIV; i++) cyc(1, 0, 0, "D", 0);
    cyc(1, 0, 0, "I", 0);
    cyc(0, 0, 0, "I", 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL restart[%0d] got {ce,clr,run,busy,ph}=%b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_midop_reset();
    logic [4:0] e, o;
    int n = 0;
    for (int unsigned i = 0; i < TB_CLR; i++) cyc(1, 0, 0, "H", 0);
    cyc(1, 0, 0, "S", 0);
    cyc(1, 0, 1, "I", 0);
    bring_up(2);
    cyc(1, 0, 1, "I", 0);
    cyc(0, 0, 0, "I", 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL midop_reset[%0d] got {ce,clr,run,busy,ph}=%b want %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_phase();
    logic [4:0] e, o;
    int n = 0;
    bring_up(3 * TB_DIV + 2);
    for (int unsigned i = 0; i < TB_DIV; i++) cyc(0, 0, 0, "D", 0);
    cyc(0, 0, 0, "I", 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL phase[%0d] got {ce,clr,run,busy,ph}=%b want %b", n, o, e);
      end
      n++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.en_i = 1'b0;
    bus.restart_i = 1'b0;
    #1;
    test_reset();
    test_stop();
    test_abort();
    test_restart();
    test_midop_reset();
    test_phase();
    started = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
